// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared types and default widths for the SPRAM arbiter
package spram_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  // The state names the SPRAM access driven during the current cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/spram_arbiter_if.sv
// rtl/spram_arbiter_if.sv - client and SPRAM-side signal bundle of the arbiter
interface spram_arbiter_if
  import spram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) ();

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              wrReq;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrReady;
  logic              rdReq;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdAck;
  logic              rdValid;
  logic [DATA_W-1:0] rdData;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWrData;
  logic              ramWe;
  logic              ramCe;
  logic [DATA_W-1:0] ramRdData;
  logic [CNT_W-1:0]  fifoCount;
  logic              overflow;

  modport slave (
    input  wrReq, wrAddr, wrData, rdReq, rdAddr, ramRdData,
    output wrReady, rdAck, rdValid, rdData, ramAddr, ramWrData, ramWe, ramCe,
           fifoCount, overflow
  );

  modport master (
    output wrReq, wrAddr, wrData, rdReq, rdAddr, ramRdData,
    input  wrReady, rdAck, rdValid, rdData, ramAddr, ramWrData, ramWe, ramCe,
           fifoCount, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; head word is visible on dout without a pop
module sync_fifo
  import spram_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = count_q;

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - shares one SPRAM between buffered writes and level-requested reads
// Reads win until a buffered write has waited MAX_STALL read cycles, then one write is forced.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STALL  = 8
) (
  input  logic             mainClk,
  input  logic             reset,
  spram_arbiter_if.slave   bus
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

  arb_state_t         state;
  arb_state_t         next_state;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_next;
  logic               ram_ce;
  logic               ram_we;
  logic               rd_ack;
  logic               rd_valid;
  logic               overflow_q;
  logic [ADDR_W-1:0]  rd_addr_q;

  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   next_count;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  assign do_push    = bus.wrReq && !full;
  assign do_pop     = (state == WRITE) && !empty;
  assign next_count = count + CNT_W'(do_push) - CNT_W'(do_pop);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (mainClk),
    .rst   (reset),
    .push  (bus.wrReq),
    .pop   (do_pop),
    .din   ({bus.wrAddr, bus.wrData}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Stall count as it will stand after this cycle; the grant decision uses it
  always_comb begin
    stall_next = stall_cnt;
    if (state == WRITE || empty) begin
      stall_next = '0;
    end else if (state == READ && stall_cnt < STALL_MAX) begin
      stall_next = stall_cnt + STALL_W'(1);
    end
  end

  // A write pushed this cycle becomes eligible for the next cycle only
  always_comb begin
    next_state = IDLE;
    if (bus.rdReq && stall_next < STALL_MAX) begin
      next_state = READ;
    end else if (next_count != '0) begin
      next_state = WRITE;
    end else if (bus.rdReq) begin
      next_state = READ;
    end
  end

  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stall_cnt  <= '0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      overflow_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state     <= next_state;
      stall_cnt <= stall_next;
      ram_ce    <= (next_state != IDLE);
      ram_we    <= (next_state == WRITE);
      rd_ack    <= (next_state == READ);
      rd_valid  <= rd_ack;
      if (next_state == READ) rd_addr_q <= bus.rdAddr;
      if (bus.wrReq && full) overflow_q <= 1'b1;
    end
  end

  assign bus.ramCe     = ram_ce;
  assign bus.ramWe     = ram_we;
  assign bus.ramAddr   = (state == WRITE) ? head[ENTRY_W-1:DATA_W] : rd_addr_q;
  assign bus.ramWrData = head[DATA_W-1:0];
  assign bus.rdAck     = rd_ack;
  assign bus.rdValid   = rd_valid;
  // SPRAM output is already registered; present it only in the valid cycle
  assign bus.rdData    = rd_valid ? bus.ramRdData : '0;
  assign bus.wrReady   = !full;
  assign bus.fifoCount = count;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - directed self-checking bench for spram_arbiter
module tb_spram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   nreads;
  bit   seen_wr;
  bit   done;

  bit   [15:0] mem [16384];
  logic [15:0] ram_q = '0;
  logic [13:0] wlog_addr [$];
  logic [15:0] wlog_data [$];

  always #5 clk = ~clk;

  spram_arbiter_if #(.ADDR_W(14), .DATA_W(16), .FIFO_DEPTH(4)) bus ();

  spram_arbiter #(
    .ADDR_W     (14),
    .DATA_W     (16),
    .FIFO_DEPTH (4),
    .MAX_STALL  (8)
  ) dut (
    .mainClk (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  // Synchronous SPRAM: read data appears the cycle after the access
  always @(posedge clk) begin
    if (bus.ramCe && bus.ramWe) begin
      mem[bus.ramAddr] <= bus.ramWrData;
      wlog_addr.push_back(bus.ramAddr);
      wlog_data.push_back(bus.ramWrData);
    end else if (bus.ramCe) begin
      ram_q <= mem[bus.ramAddr];
    end
  end
  assign bus.ramRdData = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    done = 1'b0;
    for (int i = 0; i < 24 && !done; i++) begin
      @(negedge clk);
      if (bus.fifoCount == 0 && !bus.ramCe) done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    bus.wrReq  = 1'b0;
    bus.wrAddr = '0;
    bus.wrData = '0;
    bus.rdReq  = 1'b0;
    bus.rdAddr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ramCe", bus.ramCe, 0);
    chk("rst_ramWe", bus.ramWe, 0);
    chk("rst_rdAck", bus.rdAck, 0);
    chk("rst_rdValid", bus.rdValid, 0);
    chk("rst_rdData", bus.rdData, 0);
    chk("rst_count", bus.fifoCount, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wrReady", bus.wrReady, 1);

    // single buffered write, no read pressure
    bus.wrReq = 1'b1; bus.wrAddr = 14'h0005; bus.wrData = 16'h00A3;
    @(negedge clk);
    bus.wrReq = 1'b0;
    chk("w1_ramCe", bus.ramCe, 1);
    chk("w1_ramWe", bus.ramWe, 1);
    chk("w1_ramAddr", bus.ramAddr, 14'h0005);
    chk("w1_ramWrData", bus.ramWrData, 16'h00A3);
    chk("w1_count", bus.fifoCount, 1);
    @(negedge clk);
    chk("w1_idle_ce", bus.ramCe, 0);
    chk("w1_count0", bus.fifoCount, 0);

    // read back the same address
    bus.rdReq = 1'b1; bus.rdAddr = 14'h0005;
    @(negedge clk);
    chk("r1_ack", bus.rdAck, 1);
    chk("r1_ramWe", bus.ramWe, 0);
    chk("r1_ramAddr", bus.ramAddr, 14'h0005);
    chk("r1_valid_early", bus.rdValid, 0);
    bus.rdReq = 1'b0;
    @(negedge clk);
    chk("r1_valid", bus.rdValid, 1);
    chk("r1_data", bus.rdData, 16'h00A3);
    chk("r1_ack_gone", bus.rdAck, 0);

    // continuous reads starve one write for exactly MAX_STALL reads
    bus.rdReq = 1'b1; bus.rdAddr = 14'h0010;
    bus.wrReq = 1'b1; bus.wrAddr = 14'h0020; bus.wrData = 16'h1234;
    @(negedge clk);
    bus.wrReq = 1'b0;
    nreads = 0;
    seen_wr = 1'b0;
    for (int i = 0; i < 20 && !seen_wr; i++) begin
      if (bus.ramCe && bus.ramWe) begin
        seen_wr = 1'b1;
        chk("stall_wr_noack", bus.rdAck, 0);
        chk("stall_wr_addr", bus.ramAddr, 14'h0020);
        chk("stall_wr_data", bus.ramWrData, 16'h1234);
      end else if (bus.rdAck) begin
        nreads++;
      end
      if (!seen_wr) @(negedge clk);
    end
    chk("stall_seen_wr", seen_wr, 1);
    chk("stall_nreads", nreads, 8);
    @(negedge clk);
    chk("stall_resume_ack", bus.rdAck, 1);
    chk("stall_resume_addr", bus.ramAddr, 14'h0010);

    // five pushes under read pressure overfill the 4-entry FIFO
    for (int i = 0; i < 5; i++) begin
      chk("ovf_ready_before", bus.wrReady, (i < 4) ? 1 : 0);
      bus.wrReq = 1'b1; bus.wrAddr = 14'h0100 + 14'(i); bus.wrData = 16'h0B00 + 16'(i);
      @(negedge clk);
    end
    bus.wrReq = 1'b0;
    chk("ovf_count", bus.fifoCount, 4);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_ready", bus.wrReady, 0);
    chk("ovf_still_reading", bus.rdAck, 1);
    bus.rdReq = 1'b0;
    wlog_addr.delete();
    wlog_data.delete();
    drain("ovf_drain");
    chk("ovf_nwrites", wlog_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order_addr", wlog_addr[i], 14'h0100 + 14'(i));
      chk("ovf_order_data", wlog_data[i], 16'h0B00 + 16'(i));
    end
    chk("ovf_sticky", bus.overflow, 1);

    // push and pop in the same cycle at fifoCount=2
    wlog_addr.delete();
    wlog_data.delete();
    bus.rdReq = 1'b1; bus.rdAddr = 14'h0040;
    bus.wrReq = 1'b1; bus.wrAddr = 14'h0200; bus.wrData = 16'hC000;
    @(negedge clk);
    bus.wrAddr = 14'h0201; bus.wrData = 16'hC001;
    @(negedge clk);
    bus.wrReq = 1'b0; bus.rdReq = 1'b0;
    chk("pp_count_pre", bus.fifoCount, 2);
    @(negedge clk);
    chk("pp_write_cycle", bus.ramWe, 1);
    chk("pp_head_addr", bus.ramAddr, 14'h0200);
    bus.wrReq = 1'b1; bus.wrAddr = 14'h0202; bus.wrData = 16'hC002;
    @(negedge clk);
    bus.wrReq = 1'b0;
    chk("pp_count_same", bus.fifoCount, 2);
    drain("pp_drain");
    chk("pp_nwrites", wlog_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("pp_order_addr", wlog_addr[i], 14'h0200 + 14'(i));
      chk("pp_order_data", wlog_data[i], 16'hC000 + 16'(i));
    end

    // reset with three buffered writes and a read in flight
    bus.rdReq = 1'b1; bus.rdAddr = 14'h0050;
    for (int i = 0; i < 3; i++) begin
      bus.wrReq = 1'b1; bus.wrAddr = 14'h0300 + 14'(i); bus.wrData = 16'hD000 + 16'(i);
      @(negedge clk);
    end
    bus.wrReq = 1'b0;
    chk("mr_count3", bus.fifoCount, 3);
    chk("mr_read_inflight", bus.rdAck, 1);
    rst = 1'b1;
    #1;
    chk("mr_ramCe", bus.ramCe, 0);
    chk("mr_rdValid", bus.rdValid, 0);
    chk("mr_count", bus.fifoCount, 0);
    chk("mr_wrReady", bus.wrReady, 1);
    chk("mr_overflow", bus.overflow, 0);
    @(negedge clk);
    chk("mr_rdValid_next", bus.rdValid, 0);
    bus.rdReq = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_post_ce", bus.ramCe, 0);
    chk("mr_post_count", bus.fifoCount, 0);
    chk("mr_post_ready", bus.wrReady, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
